// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one memory port among four requesters,
// driving a one-hot mux select and a valid/ready access with timeout.
module mem_port_arbiter #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       mem_ready,
  output logic [3:0] gnt,
  output logic       mem_valid,
  output logic [3:0] done,
  output logic [3:0] err,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, GRANT, ACCESS, FINISH} state_t;
  state_t state_q, state_d;
  logic [3:0] gnt_q, gnt_d, done_q, done_d, err_q, err_d, win;
  logic mem_valid_q, mem_valid_d, busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0] last_q, last_d, gnt_idx;
  // Scan from last+1 around to last; the lowest offset found wins.
  function automatic logic [3:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [3:0] w;
    logic [1:0] k;
    w = '0;
    for (int i = 3; i >= 0; i--) begin
      k = last + 2'(i + 1);
      if (r[k]) w = 4'b0001 << k;
    end
    return w;
  endfunction
  assign gnt_idx = {gnt_q[3] | gnt_q[2], gnt_q[3] | gnt_q[1]};
  assign win = rr_pick(req & ~gnt_q, gnt_idx);
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    done_d  = '0;
    err_d   = '0;
    case (state_q)
      IDLE: if (|req) begin
        state_d = GRANT;
        gnt_d   = rr_pick(req, last_q);
      end
      GRANT: begin
        state_d = ACCESS;
        cnt_d   = '0;
      end
      ACCESS: if (mem_ready) begin
        state_d = FINISH;
        done_d  = gnt_q;
      end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
        state_d = FINISH;
        err_d   = gnt_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: begin
        last_d  = gnt_idx;
        gnt_d   = win;
        state_d = |win ? GRANT : IDLE;
      end
    endcase
    mem_valid_d = state_d == ACCESS;
    busy_d      = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      cnt_q       <= '0;
      last_q      <= 2'd3;
      done_q      <= '0;
      err_q       <= '0;
      mem_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mem_valid_q <= mem_valid_d;
      busy_q      <= busy_d;
    end
  end
  assign gnt       = gnt_q;
  assign mem_valid = mem_valid_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req;
  logic mem_ready;
  logic [3:0] gnt, done, err;
  logic mem_valid, busy;
  int checks = 0;
  int failures = 0;
  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .mem_ready(mem_ready),
    .gnt(gnt), .mem_valid(mem_valid), .done(done), .err(err), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_gnt"}, 8'(gnt), 8'h0);
    chk({tag, "_valid"}, 8'(mem_valid), 8'h0);
    chk({tag, "_done"}, 8'(done), 8'h0);
    chk({tag, "_err"}, 8'(err), 8'h0);
    chk({tag, "_busy"}, 8'(busy), 8'h0);
  endtask
  initial begin
    logic [3:0] order [5];
    int n, vcnt;
    bit seen;
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;
    rst_n = 1'b0; req = '0; mem_ready = 1'b0;
    #12;
    chk_idle("reset");
    step();
    rst_n = 1'b1;
    // single access from idle
    req = 4'b0001; mem_ready = 1'b1;
    step();
    chk("c1_gnt", 8'(gnt), 8'h01);
    chk("c1_valid", 8'(mem_valid), 8'h0);
    chk("c1_busy", 8'(busy), 8'h1);
    step();
    chk("c2_valid", 8'(mem_valid), 8'h1);
    step();
    chk("c3_done", 8'(done), 8'h01);
    chk("c3_valid", 8'(mem_valid), 8'h0);
    req = '0;
    step();
    chk_idle("c4");
    // full round robin after fresh reset
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    req = 4'b1111; mem_ready = 1'b1;
    n = 0;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      step();
      chk("rr_onehot", 8'($countones(gnt) <= 1), 8'h1);
      if (done != 0) begin
        chk("rr_order", 8'(done), 8'(order[n < 5 ? n : 4]));
        chk("rr_spacing", 8'(cyc), 8'(3 * (n + 1)));
        n++;
      end
    end
    chk("rr_count", 8'(n), 8'd5);
    req = '0; mem_ready = 1'b0;
    step();
    chk("rr_idle_busy", 8'(busy), 8'h0);
    // timeout on requester 2
    req = 4'b0100;
    step();
    chk("to_gnt", 8'(gnt), 8'h04);
    vcnt = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (mem_valid) vcnt++;
      if (err != 0) seen = 1;
    end
    chk("to_seen", 8'(seen), 8'h1);
    chk("to_valid_cycles", 8'(vcnt), 8'd15);
    chk("to_err", 8'(err), 8'h04);
    chk("to_done", 8'(done), 8'h0);
    req = '0;
    step();
    chk("to_err_pulse", 8'(err), 8'h0);
    chk("to_idle", 8'(busy), 8'h0);
    // last=2, so 0 wins over 2
    req = 4'b0101; mem_ready = 1'b1;
    step();
    chk("last2_gnt", 8'(gnt), 8'h01);
    step();
    step();
    chk("last2_done", 8'(done), 8'h01);
    req = 4'b0100; mem_ready = 1'b0;
    step();
    chk("b2b_gnt", 8'(gnt), 8'h04);
    step();
    for (int i = 0; i < 13; i++) step();
    chk("late_valid14", 8'(mem_valid), 8'h1);
    chk("late_err14", 8'(err), 8'h0);
    step();
    chk("late_valid15", 8'(mem_valid), 8'h1);
    mem_ready = 1'b1;
    step();
    chk("late_done", 8'(done), 8'h04);
    chk("late_err", 8'(err), 8'h0);
    req = '0; mem_ready = 1'b0;
    step();
    chk("late_idle", 8'(busy), 8'h0);
    // request dropped while granted
    req = 4'b0010;
    step();
    chk("drop_gnt", 8'(gnt), 8'h02);
    req = '0;
    step();
    step();
    chk("drop_valid", 8'(mem_valid), 8'h1);
    chk("drop_gnt_held", 8'(gnt), 8'h02);
    mem_ready = 1'b1;
    step();
    chk("drop_done", 8'(done), 8'h02);
    chk("drop_err", 8'(err), 8'h0);
    mem_ready = 1'b0;
    step();
    chk("drop_idle", 8'(busy), 8'h0);
    // async reset mid-access
    req = 4'b1000;
    step();
    chk("rst_gnt", 8'(gnt), 8'h08);
    step();
    chk("rst_valid", 8'(mem_valid), 8'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    req = 4'b1010;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_gnt", 8'(gnt), 8'h02);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
